// File: rtl/hamming_pkg.sv
// Shared Hamming(31,26)+overall-parity definitions for the SECDED encoder and decoder.
package hamming_pkg;

  localparam int unsigned DATA_W      = 26;
  localparam int unsigned CODE_W      = 32;
  localparam int unsigned PAR_W       = 5;
  localparam int unsigned HAM_W       = 31;
  localparam int unsigned OVERALL_IDX = 31;

  localparam int unsigned PAR_POS [PAR_W] = '{0, 1, 3, 7, 15};

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_PARITY  = 2'd1;
  localparam state_t S_OVERALL = 2'd2;
  localparam state_t S_DONE    = 2'd3;

  // Codeword bit holding payload bit idx: the idx-th non-power-of-two Hamming position.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned b = 0; b < HAM_W; b++) begin
      if (((b + 1) & b) != 0) begin
        if (cnt == idx) pos = b;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_encoder_if.sv
// Handshake/data bundle of hamming_secded_encoder; err_mask exists only with HAMMING_ENC_ERR_INJECT_EN.
interface hamming_secded_encoder_if;
  import hamming_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              start;
  logic [CODE_W-1:0] encoded_data;
  logic [5:0]        parity_out;
  logic              busy;
  logic              done;
`ifdef HAMMING_ENC_ERR_INJECT_EN
  logic [CODE_W-1:0] err_mask;
`endif

  modport master (
    output data_in,
    output start,
`ifdef HAMMING_ENC_ERR_INJECT_EN
    output err_mask,
`endif
    input  encoded_data,
    input  parity_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  start,
`ifdef HAMMING_ENC_ERR_INJECT_EN
    input  err_mask,
`endif
    output encoded_data,
    output parity_out,
    output busy,
    output done
  );
endinterface

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming(31,26) parity/syndrome generator over the 31-bit position layout.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [HAM_W-1:0] i_layout,
  output logic [PAR_W-1:0] o_par
);

  // Pk's own slot is included: it is zero when encoding, and including it yields the syndrome when decoding.
  always_comb begin
    o_par = '0;
    for (int unsigned k = 0; k < PAR_W; k++) begin
      for (int unsigned b = 0; b < HAM_W; b++) begin
        if ((((b + 1) >> k) & 32'd1) != 0)
          o_par[3'(k)] = o_par[3'(k)] ^ i_layout[5'(b)];
      end
    end
  end

endmodule

// File: rtl/hamming_secded_encoder.sv
// Multi-cycle SECDED encoder: 26-bit payload -> 32-bit Hamming(31,26)+overall codeword.
// Optional HAMMING_ENC_ERR_INJECT_EN XORs a captured err_mask into the emitted codeword.
module hamming_secded_encoder
  import hamming_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  hamming_secded_encoder_if.slave  bus
);

  state_t            r_state;
  logic [HAM_W-1:0]  r_layout;
  logic [CODE_W-1:0] r_encoded;
  logic [5:0]        r_parity;
  logic              r_done;
`ifdef HAMMING_ENC_ERR_INJECT_EN
  logic [CODE_W-1:0] r_mask;
`endif

  logic [HAM_W-1:0]  w_scatter;
  logic [PAR_W-1:0]  w_par;
  logic              w_overall;

  always_comb begin
    w_scatter = '0;
    for (int unsigned i = 0; i < DATA_W; i++)
      w_scatter[5'(data_pos(i))] = bus.data_in[5'(i)];
  end

  hamming_parity_gen u_parity_gen (
    .i_layout (r_layout),
    .o_par    (w_par)
  );

  assign w_overall = ^r_layout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_layout  <= '0;
      r_encoded <= '0;
      r_parity  <= '0;
      r_done    <= 1'b0;
`ifdef HAMMING_ENC_ERR_INJECT_EN
      r_mask    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_layout <= w_scatter;
`ifdef HAMMING_ENC_ERR_INJECT_EN
            r_mask   <= bus.err_mask;
`endif
            r_state  <= S_PARITY;
          end
        end
        S_PARITY: begin
          for (int unsigned k = 0; k < PAR_W; k++)
            r_layout[5'(PAR_POS[k])] <= w_par[3'(k)];
          r_state <= S_OVERALL;
        end
        S_OVERALL: begin
          // parity_out always reflects the clean codeword, even when a mask is applied.
`ifdef HAMMING_ENC_ERR_INJECT_EN
          r_encoded <= {w_overall, r_layout} ^ r_mask;
`else
          r_encoded <= {w_overall, r_layout};
`endif
          r_parity  <= {w_overall, r_layout[15], r_layout[7], r_layout[3], r_layout[1], r_layout[0]};
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.encoded_data = r_encoded;
  assign bus.parity_out   = r_parity;
  assign bus.done         = r_done;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_hamming_secded_encoder.sv
// Scoreboard bench for hamming_secded_encoder: stimulus pushes expectations, a monitor checks each done.
module tb_hamming_secded_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_secded_encoder_if bus ();

  hamming_secded_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] code;
    logic [5:0]  par;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp  = 0;
  int unsigned n_err  = 0;
  int unsigned n_done = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent position-by-position reference: returns {parity_out, codeword}.
  function automatic logic [37:0] model(input logic [25:0] d);
    logic [31:0] c;
    logic        p;
    int          j;
    c = '0;
    j = 0;
    for (int pos = 1; pos <= 31; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        j++;
      end
    end
    for (int kk = 0; kk < 5; kk++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 31; pos++)
        if ((pos & (1 << kk)) != 0) p = p ^ c[pos-1];
      c[(1 << kk) - 1] = p;
    end
    c[31] = ^c[30:0];
    return {c[31], c[15], c[7], c[3], c[1], c[0], c};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(bus.encoded_data), 64'hDEAD_0000_0000_0000);
      end else begin
        e = sb.pop_front();
        chk("codeword", 64'(bus.encoded_data), 64'(e.code));
        chk("parity_out", 64'(bus.parity_out), 64'(e.par));
        chk("latency", 64'(cyc - e.acc), 64'd2);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b0) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic send(input logic [25:0] d, input logic [31:0] ec, input logic [5:0] ep, input bit disturb);
    wait_idle();
    bus.data_in = d;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{code: ec, par: ep, acc: cyc});
    if (disturb) begin
      bus.data_in = ~d;
      @(posedge clk); #1;
      bus.data_in = 26'h155_5555;
      @(posedge clk); #1;
    end
    bus.start   = 1'b0;
    bus.data_in = 26'($urandom);
  endtask

  task automatic send_model(input logic [25:0] d);
    logic [37:0] m;
    m = model(d);
    send(d, m[31:0], m[37:32], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    logic [25:0] d;
    logic [37:0] m;

    bus.start   = 1'b0;
    bus.data_in = '0;
`ifdef HAMMING_ENC_ERR_INJECT_EN
    bus.err_mask = '0;
`endif

    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_outputs", 64'({bus.encoded_data, bus.parity_out, bus.busy, bus.done}), 64'd0);
    end
    rst = 1'b0;

    send(26'h000_0000, 32'h0000_0000, 6'h00, 1'b0);
    send(26'h3FF_FFFF, 32'hFFFF_FFFF, 6'h3F, 1'b0);
    send(26'h000_0001, 32'h8000_0007, 6'h23, 1'b0);
    send(26'h200_0000, 32'h4000_808B, 6'h1F, 1'b0);
    // start held and data_in changed while in flight must not disturb this word
    send(26'h000_0002, 32'h8000_0019, 6'h25, 1'b1);

    for (int i = 0; i < 6; i++) send_model(26'($urandom));

    // continuous start: accepts at 4-cycle spacing, each from its own sampled data
    wait_idle();
    n0 = n_done;
    for (int i = 0; i < 12; i++) begin
      d = 26'($urandom);
      bus.data_in = d;
      bus.start   = 1'b1;
      @(posedge clk); #1;
      if (i % 4 == 0) begin
        m = model(d);
        sb.push_back('{code: m[31:0], par: m[37:32], acc: cyc});
      end
    end
    bus.start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("burst_done_count", 64'(n_done - n0), 64'd3);

    // reset while in S_PARITY drops the word
    wait_idle();
    bus.data_in = 26'h3FF_FFFF;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_in_parity", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    n0  = n_done;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_midflight", 64'({bus.encoded_data, bus.parity_out, bus.busy, bus.done}), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(n_done - n0), 64'd0);

    // reset and start on the same edge
    bus.data_in = 26'h000_0001;
    bus.start   = 1'b1;
    rst         = 1'b1;
    n0          = n_done;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_beats_start_busy", 64'(bus.busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_beats_start_done", 64'(n_done - n0), 64'd0);

    send(26'h000_0001, 32'h8000_0007, 6'h23, 1'b0);

`ifdef HAMMING_ENC_ERR_INJECT_EN
    wait_idle();
    bus.err_mask = 32'h0000_0001;
    send(26'h000_0000, 32'h0000_0001, 6'h00, 1'b0);
    bus.err_mask = '0;
`endif

    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_secded_encoder.md
Name: hamming_secded_encoder

Overview:
- Transmit-side partner of hamming_decoder: turns a 26-bit payload into a 32-bit SECDED codeword, Hamming(31,26) plus one overall parity bit, in exactly the bit layout the decoder expects.
- Multi-cycle start/done FSM. Feeds storage or the link ahead of the decoder; also used as the codeword source in decoder loopback benches.

Parameters:
- DATA_W, 26, payload width; only 26 is legal.
- CODE_W, 32, codeword width; only 32 is legal.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  26  payload; sampled only on the accepting edge.
- start  input  1  request; accepted only in S_IDLE.
- encoded_data  output  32  codeword register; holds its value until the next completion or reset.
- parity_out  output  6  {overall, P16, P8, P4, P2, P1} of the last codeword.
- busy  output  1  high in every state except S_IDLE.
- done  output  1  one-cycle pulse; encoded_data is valid in the same cycle.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: encoded_data=0, parity_out=0, busy=0, done=0, state S_IDLE, internal layout register=0.
- Codeword layout: encoded_data[i] is Hamming position i+1 for i=0..30.
  - Parity bits sit at bits 0, 1, 3, 7, 15 (P1, P2, P4, P8, P16).
  - data_in[0..25] fill the remaining bits 2,4,5,6,8..14,16..30 in ascending order.
  - Bit 31 is overall parity.
- Pk (k=1,2,4,8,16) = XOR of every position p in 1..31 with (p&k)!=0, excluding Pk itself. Even parity.
- bit31 = XOR of bits 0..30. Even parity over all 32 bits.
- FSM S_IDLE -> S_PARITY -> S_OVERALL -> S_DONE -> S_IDLE:
  - S_IDLE: start=1 at edge k scatters data_in into the layout register (parity slots 0), then -> S_PARITY.
  - S_PARITY: edge k+1 computes P1..P16 and inserts them, then -> S_OVERALL.
  - S_OVERALL: edge k+2 computes bit31 and loads encoded_data and parity_out, sets done=1, then -> S_DONE.
  - S_DONE: edge k+3 clears done, then -> S_IDLE.
- Latency: done and the new encoded_data are visible after edge k+2.
- Throughput: one word per 4 cycles. start held high continuously re-accepts at edge k+4.
- start outside S_IDLE is ignored. It is neither queued nor does it corrupt the in-flight word.
- data_in changes after edge k have no effect on the in-flight word.
- rst in any state wins over start. Return to S_IDLE on that edge, drop the in-flight word, zero all outputs, no done pulse.
- rst and start on the same edge: reset wins, start is dropped.

Optional Feature:
- Macro HAMMING_ENC_ERR_INJECT_EN.
- Defined:
  - Adds input err_mask[31:0], captured together with data_in on the accepting edge.
  - In S_OVERALL, encoded_data = (correct codeword) XOR err_mask.
  - parity_out still reports the uncorrupted parity.
  - Purpose: exercising decoder SEC/DED paths.
- Undefined: port absent, no corruption logic synthesised.

Decomposition:
- Shared package hamming_pkg:
  - DATA_W, CODE_W, PAR_W=5.
  - Parity position constants {0,1,3,7,15}, overall index 31.
  - State enum.
  - Data-to-codeword position map function (data index -> codeword bit). Also used by the decoder for extraction.
- One sub-module, hamming_parity_gen: purely combinational, 31-bit layout in, 5 Hamming parity bits out. Reused by the decoder for syndrome generation.

Test Plan:
- rst=1 for 3 cycles, then data_in=0000000 with start -> all outputs 0 during reset; done pulses exactly once, 2 cycles after acceptance, with encoded_data=00000000, parity_out=00.
- data_in=3FFFFFF -> encoded_data=FFFFFFFF, parity_out=3F. data_in=0000001 -> 80000007. data_in=2000000 -> 4000808B, parity_out=1F.
- start held high for 12 cycles while data_in changes every cycle -> exactly 3 done pulses, at 4-cycle spacing. Each codeword matches the data_in sampled on its accepting edge.
- rst asserted while in S_PARITY -> S_IDLE next cycle, no done pulse, encoded_data=00000000, busy=0.
- Loopback into hamming_decoder, 100 random payloads:
  - No flip -> decoded equals payload, no error flags.
  - Single-bit flip at each index 0..31 -> corrected payload, single_error_detected=1.
  - Flip pairs (0,3), (5,8), (10,13) -> double_error_detected=1.
- With HAMMING_ENC_ERR_INJECT_EN: data_in=0000000, err_mask=00000001 -> encoded_data=00000001, parity_out=00.
